// File: rtl/mem_pipe_ram.sv
// Single-port synchronous RAM with a valid/ready request port, per-byte write
// enables, out-of-range detection and a fixed-latency in-order read pipeline.
module mem_pipe_ram #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              wr_err,
    output logic              busy
);

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_ready;
    logic                r_wr_err;
    logic                r_busy;
    logic [READ_LAT-1:0] r_pv;
    logic [READ_LAT-1:0] r_pe;
    logic [DATA_W-1:0]   r_pd [READ_LAT];

    logic                w_accept;
    logic                w_in_range;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [DATA_W-1:0]   w_rd_word;
    logic [READ_LAT-1:0] w_pv_next;

    // Request decode and array sample
    always_comb begin
        w_accept   = req_valid & r_ready;
        w_in_range = ({1'b0, req_addr} < DEPTH_L);
        w_rd_acc   = w_accept & ~req_we;
        w_wr_acc   = w_accept & req_we;
        w_rd_word  = '0;
        if (w_in_range) begin
            w_rd_word = r_mem[req_addr];
        end
        w_pv_next  = (r_pv << 1) | READ_LAT'(w_rd_acc);
    end

    // Storage array: byte-masked writes, contents deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr_acc && w_in_range) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control flags and read-return shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready  <= 1'b0;
            r_wr_err <= 1'b0;
            r_busy   <= 1'b0;
            r_pv     <= '0;
            r_pe     <= '0;
            for (int unsigned k = 0; k < READ_LAT; k++) begin
                r_pd[k] <= '0;
            end
        end else begin
            r_ready  <= 1'b1;
            r_wr_err <= w_wr_acc & ~w_in_range;
            r_pv     <= w_pv_next;
            r_busy   <= |w_pv_next;
            r_pe[0]  <= w_rd_acc & ~w_in_range;
            if (w_rd_acc) begin
                r_pd[0] <= w_rd_word;
            end
            // Data stages only advance behind a valid so rd_data holds between returns
            for (int unsigned k = 1; k < READ_LAT; k++) begin
                r_pe[k] <= r_pe[k-1];
                if (r_pv[k-1]) begin
                    r_pd[k] <= r_pd[k-1];
                end
            end
        end
    end

    assign req_ready = r_ready;
    assign rd_valid  = r_pv[READ_LAT-1];
    assign rd_data   = r_pd[READ_LAT-1];
    assign rd_err    = r_pe[READ_LAT-1];
    assign wr_err    = r_wr_err;
    assign busy      = r_busy;

endmodule
